// File: rtl/aes_128_round_ctrl_pkg.sv
// Shared definitions for the AES-128 round controller.
//   state_t      : controller FSM states (IDLE, LOAD, ROUND, DONE)
//   NUM_ROUNDS   : number of AES-128 rounds after the initial AddRoundKey
//   rcon_lookup  : key-schedule round constant for a given round number
package aes_128_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_ROUNDS = 10;

    // Rounds 1..10 use the AES Rcon sequence; anything else yields 0 so the
    // key schedule sees no constant outside the round loop.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1B;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_128_round_ctrl_if.sv
// Block handshake between the round controller and its neighbours.
//   in_valid / in_ready   : plaintext+key offered / controller can take it
//   out_valid / out_ready : ciphertext ready / consumer takes it
// master = upstream/downstream environment, slave = controller.
interface aes_128_round_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/aes_128_round_ctrl.sv
// AES-128 round controller: sequences an external round datapath through
// key load, ten rounds and result hand-off, one block in flight at a time.
// Ports:
//   clk        : clock
//   kill_n     : asynchronous active-low reset
//   flush      : synchronous abort, drops the block in flight
//   hs         : in/out valid-ready handshake (slave side)
//   key_ld     : one-cycle pulse, datapath loads key + initial AddRoundKey
//   round_step : one-cycle pulse at the start of every round
//   round_idx  : current round number 0..10
//   rcon       : key-schedule round constant for round_idx
//   mix_bypass : 1 = MixColumns pass-through, 0 = mix
// All outputs are registered.
module aes_128_round_ctrl
    import aes_128_pkg::*;
#(
    parameter int STAGE_LAT = 1
) (
    input  logic                       clk,
    input  logic                       kill_n,
    input  logic                       flush,
    aes_128_round_ctrl_if.slave        hs,
    output logic                       key_ld,
    output logic                       round_step,
    output logic [3:0]                 round_idx,
    output logic [7:0]                 rcon,
    output logic                       mix_bypass
);

    localparam logic [3:0] WAIT_RELOAD = 4'(STAGE_LAT - 1);
    localparam logic [3:0] LAST_ROUND  = 4'(NUM_ROUNDS);

    state_t     state_reg, state_next;
    logic [3:0] idx_reg, idx_next;
    logic [3:0] wait_reg, wait_next;
    logic       step_next;

    logic       in_ready_reg;
    logic       out_valid_reg;
    logic       key_ld_reg;
    logic       round_step_reg;
    logic       mix_bypass_reg;
    logic [7:0] rcon_reg;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        wait_next  = wait_reg;
        step_next  = 1'b0;
        if (flush) begin
            state_next = IDLE;
            idx_next   = 4'd0;
            wait_next  = 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Acceptance uses the registered in_ready, which stays low
                    // until the first edge after reset release.
                    if (hs.in_valid && in_ready_reg) begin
                        state_next = LOAD;
                        idx_next   = 4'd0;
                    end
                end
                LOAD: begin
                    state_next = ROUND;
                    idx_next   = 4'd1;
                    wait_next  = WAIT_RELOAD;
                    step_next  = 1'b1;
                end
                ROUND: begin
                    if (wait_reg != 4'd0) begin
                        wait_next = wait_reg - 4'd1;
                    end else if (idx_reg < LAST_ROUND) begin
                        idx_next  = idx_reg + 4'd1;
                        wait_next = WAIT_RELOAD;
                        step_next = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (hs.out_ready) begin
                        state_next = IDLE;
                        idx_next   = 4'd0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = 4'd0;
                    wait_next  = 4'd0;
                end
            endcase
        end
    end

    // Outputs are derived from the next-state values so every output is a
    // flop that lines up with the state it describes.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state_reg      <= IDLE;
            idx_reg        <= 4'd0;
            wait_reg       <= 4'd0;
            in_ready_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            key_ld_reg     <= 1'b0;
            round_step_reg <= 1'b0;
            mix_bypass_reg <= 1'b1;
            rcon_reg       <= 8'h00;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            wait_reg       <= wait_next;
            in_ready_reg   <= (state_next == IDLE);
            out_valid_reg  <= (state_next == DONE);
            key_ld_reg     <= (state_next == LOAD);
            round_step_reg <= step_next;
            // The final round skips MixColumns; outside ROUND nothing mixes.
            mix_bypass_reg <= !((state_next == ROUND) && (idx_next != LAST_ROUND));
            rcon_reg       <= (state_next == ROUND) ? rcon_lookup(idx_next) : 8'h00;
        end
    end

    assign hs.in_ready  = in_ready_reg;
    assign hs.out_valid = out_valid_reg;
    assign key_ld       = key_ld_reg;
    assign round_step   = round_step_reg;
    assign round_idx    = idx_reg;
    assign rcon         = rcon_reg;
    assign mix_bypass   = mix_bypass_reg;

endmodule
